// File: rtl/ysyx_22041752_exe_stage_ctrl_pkg.sv
// Shared EXE-stage definitions: decode->exe bus width and controller state encodings.
package ysyx_22041752_exe_stage_ctrl_pkg;

  localparam int DS_TO_ES_BUS_WD = 200;

  typedef enum logic [1:0] {
    ES_ST_IDLE  = 2'd0,
    ES_ST_ISSUE = 2'd1,
    ES_ST_WAIT  = 2'd2,
    ES_ST_DONE  = 2'd3
  } es_state_e;

endpackage

// File: rtl/ysyx_22041752_exe_stage_ctrl.sv
// EXE stage controller: latches the ID payload, sequences multi-cycle mul/div,
// holds the captured result until MEM accepts it, and counts mul/div stall cycles.
module ysyx_22041752_exe_stage_ctrl
  import ysyx_22041752_exe_stage_ctrl_pkg::*;
#(
  parameter int BUS_W  = DS_TO_ES_BUS_WD,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ds_to_es_valid,
  input  logic [BUS_W-1:0]  ds_to_es_bus,
  input  logic              ds_is_mul,
  input  logic              ds_is_div,
  output logic              es_allowin,
  output logic              es_valid,
  output logic [BUS_W-1:0]  es_bus,
  output logic              md_issue,
  output logic              md_flush,
  input  logic              mul_out_valid,
  input  logic              div_out_valid,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] es_result,
  input  logic              ms_allowin,
  output logic              es_to_ms_valid,
  output logic [CNT_W-1:0]  md_stall_cnt
);

  es_state_e         state_q, state_d;
  logic              es_valid_q, es_valid_d;
  logic [BUS_W-1:0]  es_bus_q, es_bus_d;
  logic              is_mul_q, is_mul_d;
  logic              is_div_q, is_div_d;
  logic [DATA_W-1:0] md_res_q, md_res_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic is_md_q, sel_valid, es_ready_go, accept;

  always_comb begin
    is_md_q     = is_mul_q | is_div_q;
    sel_valid   = is_mul_q ? mul_out_valid : div_out_valid;
    es_ready_go = !is_md_q | (state_q == ES_ST_DONE);
    es_allowin  = !es_valid_q | (es_ready_go & ms_allowin);
    accept      = ds_to_es_valid & es_allowin & !flush;

    state_d     = state_q;
    es_valid_d  = es_valid_q;
    es_bus_d    = es_bus_q;
    is_mul_d    = is_mul_q;
    is_div_d    = is_div_q;
    md_res_d    = md_res_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ES_ST_ISSUE, ES_ST_WAIT: begin
        if (sel_valid) begin
          state_d  = ES_ST_DONE;
          md_res_d = alu_result;
        end else begin
          state_d  = ES_ST_WAIT;
        end
      end
      ES_ST_DONE: if (ms_allowin) state_d = ES_ST_IDLE;
      default: ;
    endcase

    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
      is_mul_d   = accept & ds_is_mul;
      is_div_d   = accept & ds_is_div;
    end
    // allowin is only high in IDLE/DONE, so this also covers back-to-back md
    if (accept) begin
      es_bus_d = ds_to_es_bus;
      if (ds_is_mul | ds_is_div) state_d = ES_ST_ISSUE;
    end

    if (es_valid_q && (state_q == ES_ST_ISSUE || state_q == ES_ST_WAIT) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (flush) begin
      state_d    = ES_ST_IDLE;
      es_valid_d = 1'b0;
      is_mul_d   = 1'b0;
      is_div_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ES_ST_IDLE;
      es_valid_q  <= 1'b0;
      es_bus_q    <= '0;
      is_mul_q    <= 1'b0;
      is_div_q    <= 1'b0;
      md_res_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      es_valid_q  <= es_valid_d;
      es_bus_q    <= es_bus_d;
      is_mul_q    <= is_mul_d;
      is_div_q    <= is_div_d;
      md_res_q    <= md_res_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign es_valid       = es_valid_q;
  assign es_bus         = es_bus_q;
  assign md_issue       = es_valid_q & (state_q == ES_ST_ISSUE);
  assign md_flush       = flush | reset;
  assign es_result      = (state_q == ES_ST_DONE) ? md_res_q : alu_result;
  assign es_to_ms_valid = es_valid_q & es_ready_go;
  assign md_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22041752_exe_stage_ctrl.sv
// Randomized scoreboard bench for the EXE stage controller with a transaction-level model.
module tb_ysyx_22041752_exe_stage_ctrl;

  localparam int BUS_W  = 200;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int N_CYC  = 3000;

  logic              clk, reset, flush;
  logic              ds_to_es_valid, ds_is_mul, ds_is_div;
  logic [BUS_W-1:0]  ds_to_es_bus;
  logic              es_allowin, es_valid, md_issue, md_flush;
  logic [BUS_W-1:0]  es_bus;
  logic              mul_out_valid, div_out_valid, ms_allowin, es_to_ms_valid;
  logic [DATA_W-1:0] alu_result, es_result;
  logic [CNT_W-1:0]  md_stall_cnt;

  ysyx_22041752_exe_stage_ctrl #(.BUS_W(BUS_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .ds_is_mul(ds_is_mul), .ds_is_div(ds_is_div),
    .es_allowin(es_allowin), .es_valid(es_valid), .es_bus(es_bus),
    .md_issue(md_issue), .md_flush(md_flush),
    .mul_out_valid(mul_out_valid), .div_out_valid(div_out_valid),
    .alu_result(alu_result), .es_result(es_result),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .md_stall_cnt(md_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Instruction-level view of the stage: what it holds and how far its mul/div got.
  bit               m_occ, m_md, m_mul, m_done, m_issued;
  int               m_cyc, m_lat, m_cnt;
  logic [BUS_W-1:0] m_pay;

  function automatic logic [DATA_W-1:0] alu_f(input logic [BUS_W-1:0] p);
    return p[63:0] ^ p[127:64] ^ 64'hDEAD_BEEF_0123_4567;
  endfunction

  function automatic logic [DATA_W-1:0] md_g(input logic [BUS_W-1:0] p, input bit mul);
    if (mul) return p[63:0] * p[127:64];
    return (p[63:0] ^ p[191:128]) + 64'd3;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [223:0] w;
    for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom();
    return w[BUS_W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected result whenever MEM takes one.
  always @(negedge clk) begin
    #2;
    if (started && !reset && es_to_ms_valid && ms_allowin && !flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none at %0t", es_result, $time);
      end else begin
        chk("es_result", es_result, exp_q.pop_front());
      end
    end
  end

  initial begin
    bit busy, fire, acc, exp_ready, exp_allow, exp_tmv;
    logic [BUS_W-1:0] pay;

    reset = 1'b1; flush = 1'b0; ds_to_es_valid = 1'b0; ds_is_mul = 1'b0; ds_is_div = 1'b0;
    ds_to_es_bus = '0; mul_out_valid = 1'b0; div_out_valid = 1'b0;
    alu_result = '0; ms_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_es_valid", 64'(es_valid), 64'd0);
    chk("rst_to_ms_valid", 64'(es_to_ms_valid), 64'd0);
    chk("rst_md_issue", 64'(md_issue), 64'd0);
    chk("rst_stall_cnt", 64'(md_stall_cnt), 64'd0);
    chk("rst_md_flush", 64'(md_flush), 64'd1);
    chk("rst_es_bus", es_bus[63:0], 64'd0);

    m_occ = 0; m_md = 0; m_mul = 0; m_done = 0; m_issued = 0;
    m_cyc = 0; m_lat = 0; m_cnt = 0; m_pay = '0;
    @(negedge clk);
    reset = 1'b0;
    started = 1;

    for (int c = 0; c < N_CYC; c++) begin
      if (c != 0) @(negedge clk);
      flush          = ($urandom_range(0, 19) == 0);
      ms_allowin     = ($urandom_range(0, 9) < 7);
      ds_to_es_valid = ($urandom_range(0, 9) < 6);
      begin
        int t = $urandom_range(0, 2);
        ds_is_mul = (t == 1);
        ds_is_div = (t == 2);
      end
      pay = rand_bus();
      ds_to_es_bus = pay;

      busy = m_occ & m_md & !m_done;
      fire = busy & (m_cyc == m_lat);
      if (m_occ & m_md) begin
        // selected unit only pulses when its result is due, except outside ISSUE/WAIT
        if (m_mul) begin
          mul_out_valid = fire | (!busy & ($urandom_range(0, 3) == 0));
          div_out_valid = ($urandom_range(0, 3) == 0);
        end else begin
          div_out_valid = fire | (!busy & ($urandom_range(0, 3) == 0));
          mul_out_valid = ($urandom_range(0, 3) == 0);
        end
      end else begin
        mul_out_valid = ($urandom_range(0, 3) == 0);
        div_out_valid = ($urandom_range(0, 3) == 0);
      end
      if (fire)                alu_result = md_g(m_pay, m_mul);
      else if (m_occ & !m_md)  alu_result = alu_f(es_bus);
      else                     alu_result = {$urandom(), $urandom()};
      #1;

      exp_ready = !m_md | m_done;
      exp_allow = !m_occ | (exp_ready & ms_allowin);
      exp_tmv   = m_occ & exp_ready;
      chk("es_allowin", 64'(es_allowin), 64'(exp_allow));
      chk("es_valid", 64'(es_valid), 64'(m_occ));
      chk("es_to_ms_valid", 64'(es_to_ms_valid), 64'(exp_tmv));
      chk("md_issue", 64'(md_issue), 64'(m_occ & m_md & !m_issued));
      chk("md_flush", 64'(md_flush), 64'(flush));
      chk("md_stall_cnt", 64'(md_stall_cnt), 64'(m_cnt));
      if (m_occ) chk("es_bus", es_bus[63:0] ^ es_bus[199:136], m_pay[63:0] ^ m_pay[199:136]);

      acc = ds_to_es_valid & exp_allow & !flush;
      if (busy) begin
        m_cnt    = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        m_issued = 1;
        if (fire) m_done = 1;
        else      m_cyc++;
      end
      if (flush) begin
        m_occ = 0;
        exp_q.delete();
      end else if (exp_allow) begin
        m_occ = ds_to_es_valid;
        if (acc) begin
          m_md     = ds_is_mul | ds_is_div;
          m_mul    = ds_is_mul;
          m_pay    = pay;
          m_done   = 0;
          m_issued = 0;
          m_cyc    = 0;
          m_lat    = $urandom_range(0, 4);
          exp_q.push_back(m_md ? md_g(pay, ds_is_mul) : alu_f(pay));
        end
      end
    end

    #5;
    chk("stall_cnt_saturated", 64'(md_stall_cnt), 64'(CNT_MAX));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
